// File: rtl/conv1d_pkg.sv
// Shared constants and enums for the conv1d configuration path.
package conv1d_pkg;

  localparam int BW         = 8;
  localparam int BIAS_BW    = 32;
  localparam int FILTER_LEN = 3;
  localparam int BANK_BW    = 2;

  typedef enum logic [BANK_BW-1:0] {
    BANK_W0   = 2'd0,
    BANK_W1   = 2'd1,
    BANK_W2   = 2'd2,
    BANK_BIAS = 2'd3
  } bank_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_LOAD,
    ST_WRITE
  } state_e;

endpackage

// File: rtl/cfg_word_packer.sv
// Byte-to-vector assembler: each loaded byte lands in element byte_cnt; done is combinational
// with the final byte of a word. No backpressure of its own; the caller gates load_i.
module cfg_word_packer #(
  parameter  int BW         = 8,
  parameter  int COLUMN_LEN = 13,
  localparam int VECTOR_BW  = COLUMN_LEN * BW,
  localparam int CNT_BW     = $clog2(COLUMN_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [BW-1:0]        byte_i,
  input  logic [CNT_BW-1:0]    word_len_i,
  output logic [VECTOR_BW-1:0] data_o,
  output logic                 done_o
);

  logic [CNT_BW-1:0]    byte_cnt_q;
  logic [VECTOR_BW-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      byte_cnt_q <= '0;
      data_q     <= '0;
    end else if (clear_i) begin
      byte_cnt_q <= '0;
      data_q     <= '0;
    end else if (load_i) begin
      byte_cnt_q <= byte_cnt_q + 1'b1;
      for (int i = 0; i < COLUMN_LEN; i++) begin
        if (int'(byte_cnt_q) == i) data_q[i*BW +: BW] <= byte_i;
      end
    end
  end

  assign done_o = load_i && (byte_cnt_q == word_len_i - 1'b1);
  assign data_o = data_q;

endmodule

// File: rtl/conv1d_cfg_ctrl.sv
// Parameter reload sequencer and feature gate for conv1d; write strobe one cycle after a word's last byte.
// Feature stream is held off while a reload is pending or running; an open frame is drained first.
module conv1d_cfg_ctrl
  import conv1d_pkg::*;
#(
  parameter  int FRAME_LEN   = 50,
  parameter  int COLUMN_LEN  = 13,
  parameter  int NUM_FILTERS = 8,
  parameter  int BW          = conv1d_pkg::BW,
  parameter  int BIAS_BYTES  = BIAS_BW / conv1d_pkg::BW,
  localparam int VECTOR_BW   = COLUMN_LEN * BW,
  localparam int ADDR_BW     = $clog2(NUM_FILTERS),
  localparam int CNT_BW      = $clog2(COLUMN_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [BW-1:0]        cfg_data_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  output logic                 busy_o,
  output logic                 loaded_o,
  output logic                 wr_en_o,
  output logic                 rd_en_o,
  output logic [BANK_BW-1:0]   bank_o,
  output logic [ADDR_BW-1:0]   addr_o,
  output logic [VECTOR_BW-1:0] wr_data_o,
  input  logic [VECTOR_BW-1:0] s_data_i,
  input  logic                 s_valid_i,
  input  logic                 s_last_i,
  output logic                 s_ready_o,
  output logic [VECTOR_BW-1:0] m_data_o,
  output logic                 m_valid_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
);

  if (BIAS_BYTES > COLUMN_LEN || FRAME_LEN < 1 || FILTER_LEN != int'(BANK_BIAS)) begin : g_bad_cfg
    $error("conv1d_cfg_ctrl: inconsistent parameter set");
  end

  localparam logic [ADDR_BW-1:0] ADDR_LAST = ADDR_BW'(NUM_FILTERS - 1);

  state_e               state_q, state_d;
  bank_e                bank_q;
  logic [ADDR_BW-1:0]   addr_q;
  logic                 loaded_q;
  logic                 in_frame_q;
  logic                 gate_open;
  logic                 beat_acc;
  logic                 in_frame_nxt;
  logic                 cfg_acc;
  logic                 start_go;
  logic                 write_last;
  logic                 pk_clear;
  logic                 pk_done;
  logic [CNT_BW-1:0]    word_len;

  // In DRAIN only the frame already in flight may complete.
  assign gate_open = ((state_q == ST_IDLE) && loaded_q) || ((state_q == ST_DRAIN) && in_frame_q);
  assign m_valid_o = s_valid_i & gate_open;
  assign s_ready_o = m_ready_i & gate_open;
  assign m_data_o  = s_data_i;
  assign m_last_o  = s_last_i;

  assign beat_acc     = s_valid_i & s_ready_o;
  assign in_frame_nxt = beat_acc ? ~s_last_i : in_frame_q;

  assign cfg_ready_o = (state_q == ST_LOAD);
  assign cfg_acc     = cfg_valid_i & cfg_ready_o;
  assign start_go    = (state_q == ST_IDLE) && start_i;
  assign write_last  = (bank_q == BANK_BIAS) && (addr_q == ADDR_LAST);
  assign word_len    = (bank_q == BANK_BIAS) ? CNT_BW'(BIAS_BYTES) : CNT_BW'(COLUMN_LEN);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wr_en_o  = 1'b0;
    pk_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = in_frame_nxt ? ST_DRAIN : ST_LOAD;
          pk_clear = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!in_frame_nxt) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (pk_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en_o  = 1'b1;
        pk_clear = 1'b1;
        state_d  = write_last ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bank_q     <= BANK_W0;
      addr_q     <= '0;
      loaded_q   <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      if (beat_acc) in_frame_q <= ~s_last_i;
      if (start_go) begin
        loaded_q <= 1'b0;
        bank_q   <= BANK_W0;
        addr_q   <= '0;
      end else if (state_q == ST_WRITE) begin
        if (addr_q == ADDR_LAST) begin
          addr_q <= '0;
          bank_q <= bank_e'(bank_q + 1'b1);
        end else begin
          addr_q <= addr_q + 1'b1;
        end
        if (write_last) loaded_q <= 1'b1;
      end
    end
  end

  cfg_word_packer #(
    .BW         (BW),
    .COLUMN_LEN (COLUMN_LEN)
  ) u_packer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (pk_clear),
    .load_i     (cfg_acc),
    .byte_i     (cfg_data_i),
    .word_len_i (word_len),
    .data_o     (wr_data_o),
    .done_o     (pk_done)
  );

  assign busy_o   = (state_q != ST_IDLE);
  assign loaded_o = loaded_q;
  assign rd_en_o  = 1'b0;
  assign bank_o   = bank_q;
  assign addr_o   = addr_q;

endmodule

// File: tb/tb_conv1d_cfg_ctrl.sv
// Directed bench for conv1d_cfg_ctrl: write-port scoreboard plus stream-gate checks.
module tb_conv1d_cfg_ctrl;

  localparam int VBW = 104;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_i;
  logic [7:0]     cfg_data;
  logic           cfg_valid;
  logic           cfg_ready_o, busy_o, loaded_o, wr_en_o, rd_en_o;
  logic [1:0]     bank_o;
  logic [2:0]     addr_o;
  logic [VBW-1:0] wr_data_o;
  logic [VBW-1:0] s_data;
  logic           s_valid, s_last, s_ready_o;
  logic [VBW-1:0] m_data_o;
  logic           m_valid_o, m_last_o;
  logic           m_ready;

  always #5 clk = ~clk;

  conv1d_cfg_ctrl dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start_i),
    .cfg_data_i  (cfg_data),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready_o),
    .busy_o      (busy_o),
    .loaded_o    (loaded_o),
    .wr_en_o     (wr_en_o),
    .rd_en_o     (rd_en_o),
    .bank_o      (bank_o),
    .addr_o      (addr_o),
    .wr_data_o   (wr_data_o),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_last_i    (s_last),
    .s_ready_o   (s_ready_o),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_last_o    (m_last_o),
    .m_ready_i   (m_ready)
  );

  typedef struct packed {
    logic [1:0]     bank;
    logic [2:0]     addr;
    logic [VBW-1:0] data;
  } wr_t;

  wr_t            exp_q[$];
  wr_t            log_a[0:31];
  int             n_cmp = 0;
  int             n_fail = 0;
  int             n_wr = 0;
  int             wr_base = 0;
  bit             acc_prev = 1'b0;

  int             m_k;
  int             lb;
  logic [1:0]     m_bank;
  logic [2:0]     m_addr;
  logic [VBW-1:0] cur;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    wr_t got;
    wr_t e;
    if (rst_n && wr_en_o) begin
      got = {bank_o, addr_o, wr_data_o};
      if (n_wr - wr_base < 32) log_a[n_wr - wr_base] = got;
      n_wr++;
      check("wr_latency", acc_prev, 1);
      check("wr_cfg_ready", cfg_ready_o, 0);
      check("wr_exp_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_bank", bank_o, e.bank);
        check("wr_addr", addr_o, e.addr);
        check("wr_data", wr_data_o, e.data);
      end
    end
    acc_prev = rst_n && cfg_valid && cfg_ready_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    m_k = 0; lb = 0; m_bank = 2'd0; m_addr = 3'd0; cur = '0;
    wr_base = n_wr;
  endtask

  task automatic start_load();
    reset_model();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_bytes(input int n, input bit gaps, input int start_at);
    for (int i = 0; i < n; i++) begin
      int budget;
      bit acc;
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) begin
          cfg_valid = 1'b0;
          tick();
        end
      end
      cfg_valid = 1'b1;
      cfg_data  = 8'(lb);
      start_i   = (i == start_at);
      budget = 0;
      acc = 1'b0;
      while (!acc && budget < 20) begin
        @(negedge clk);
        acc = cfg_ready_o;
        tick();
        start_i = 1'b0;
        budget++;
      end
      if (!acc) begin
        check("cfg_accept_timeout", 0, 1);
        cfg_valid = 1'b0;
        return;
      end
      cur[m_k*8 +: 8] = cfg_data;
      m_k++;
      lb++;
      if (m_k == ((m_bank == 2'd3) ? 4 : 13)) begin
        exp_q.push_back({m_bank, m_addr, cur});
        cur = '0;
        m_k = 0;
        if (m_addr == 3'd7) begin
          m_addr = 3'd0;
          m_bank = m_bank + 2'd1;
        end else begin
          m_addr = m_addr + 3'd1;
        end
      end
    end
    cfg_valid = 1'b0;
  endtask

  // Called in the cycle of the final write strobe.
  task automatic check_load_done();
    @(negedge clk);
    check("last_wr_en", wr_en_o, 1);
    check("loaded_before_last", loaded_o, 0);
    tick();
    @(negedge clk);
    check("loaded_after_last", loaded_o, 1);
    check("busy_after_load", busy_o, 0);
    check("wr_en_after_load", wr_en_o, 0);
    check("write_count", n_wr - wr_base, 32);
    check("scoreboard_empty", exp_q.size(), 0);
    tick();
  endtask

  task automatic beat(input logic [VBW-1:0] d, input logic last, input logic pass);
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk);
    check("gate_m_valid", m_valid_o, pass);
    check("gate_s_ready", s_ready_o, pass);
    check("pass_data", m_data_o, d);
    check("pass_last", m_last_o, last);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
    s_data = '0; s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b1;
    reset_model();
    #12;
    check("rst_loaded", loaded_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cfg_ready", cfg_ready_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_bank", bank_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rd_en", rd_en_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("noload_m_valid", m_valid_o, 0);
    check("noload_s_ready", s_ready_o, 0);
    check("noload_loaded", loaded_o, 0);
    tick();
    s_valid = 1'b0;

    // Full load, back-to-back bytes.
    start_load();
    @(negedge clk);
    check("load_busy", busy_o, 1);
    check("load_cfg_ready", cfg_ready_o, 1);
    tick();
    send_bytes(344, 1'b0, -1);
    check_load_done();
    check("first_write", log_a[0], {2'd0, 3'd0, 104'h0C0B0A09080706050403020100});
    check("bias_write0", log_a[24], {2'd3, 3'd0, 104'h3B3A3938});
    check("final_bank_addr", {log_a[31].bank, log_a[31].addr}, {2'd3, 3'd7});

    // Full load with random cfg_valid gaps.
    start_load();
    send_bytes(344, 1'b1, -1);
    check_load_done();

    // Frame in flight when reload is requested.
    beat(104'hF001, 1'b0, 1'b1);
    beat(104'hF002, 1'b0, 1'b1);
    start_load();
    cfg_valid = 1'b1; cfg_data = 8'hAA;
    @(negedge clk);
    check("drain_busy", busy_o, 1);
    check("drain_cfg_ready", cfg_ready_o, 0);
    tick();
    beat(104'hF003, 1'b0, 1'b1);
    beat(104'hF004, 1'b0, 1'b1);
    beat(104'hF005, 1'b1, 1'b1);
    cfg_valid = 1'b0;
    s_valid = 1'b1; s_data = 104'hB001;
    @(negedge clk);
    check("cfg_ready_after_last", cfg_ready_o, 1);
    check("next_frame_m_valid", m_valid_o, 0);
    check("next_frame_s_ready", s_ready_o, 0);
    tick();
    s_valid = 1'b0;
    // start_i pulsed mid-load must be ignored.
    send_bytes(344, 1'b0, 100);
    check_load_done();

    // Single-beat frame accepted in the same cycle as start_i.
    reset_model();
    s_valid = 1'b1; s_last = 1'b1; s_data = 104'h9; start_i = 1'b1;
    @(negedge clk);
    check("same_cycle_s_ready", s_ready_o, 1);
    tick();
    start_i = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    check("same_cycle_to_load", cfg_ready_o, 1);
    tick();

    // Async reset part way through a load.
    send_bytes(100, 1'b0, -1);
    #2;
    rst_n = 1'b0;
    s_valid = 1'b1;
    #1;
    check("arst_loaded", loaded_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_cfg_ready", cfg_ready_o, 0);
    check("arst_wr_en", wr_en_o, 0);
    check("arst_bank", bank_o, 0);
    check("arst_addr", addr_o, 0);
    check("arst_wr_data", wr_data_o, 0);
    check("arst_m_valid", m_valid_o, 0);
    check("partial_writes", n_wr - wr_base, 7);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_m_valid", m_valid_o, 0);
    check("post_rst_loaded", loaded_o, 0);
    tick();
    s_valid = 1'b0;
    start_load();
    send_bytes(344, 1'b0, -1);
    check_load_done();
    check("reload_first_write", log_a[0], {2'd0, 3'd0, 104'h0C0B0A09080706050403020100});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
